// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding and default widths.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int PERF_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        REPLAY = 2'd3
    } memState_e;

endpackage

// File: rtl/mem_perf_counter.sv
// Saturating event counter with increment enable and asynchronous active-low clear.
module mem_perf_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// EX/MEM sequencing controller: D-cache miss refill handshake, pipeline stall and branch redirect.
// Optional performance counters are built when MEM_CTRL_PERF_EN is defined.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic              hitM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic              branchM,
    input  logic              zeroM,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [ADDR_W-1:0] memReqAddr,
    output logic              memReqWrite,
    input  logic              memRespValid,
    output logic              stall,
    output logic              bubbleW,
    output logic              flushD,
    output logic              flushE,
    output logic              pcSrc,
    output logic [PERF_W-1:0] missCount,
    output logic [PERF_W-1:0] stallCycles
);

    memState_e state, nextState;
    logic      miss;
    logic      taken;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState   = state;
        miss        = 1'b0;
        memReqValid = 1'b0;
        stall       = 1'b0;
        taken       = 1'b0;
        unique case (state)
            IDLE: begin
                miss = (memReadM | memWriteM) & ~hitM;
                if (miss)
                    nextState = REQ;
            end
            REQ: begin
                memReqValid = 1'b1;
                if (memReqReady)
                    nextState = WAIT;
            end
            WAIT: begin
                if (memRespValid)
                    nextState = REPLAY;
            end
            REPLAY:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
        // A miss outranks a branch; the branch stays in EX/MEM and fires once the stall drops.
        stall = miss | (state != IDLE);
        taken = branchM & zeroM & ~stall;
    end

    assign bubbleW = stall;
    assign pcSrc   = taken;
    assign flushD  = taken;
    assign flushE  = taken;

    // Request fields are captured on the miss edge and held for the whole refill.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            memReqAddr  <= '0;
            memReqWrite <= 1'b0;
        end else if (miss) begin
            memReqAddr  <= addrM;
            memReqWrite <= memWriteM;
        end
    end

`ifdef MEM_CTRL_PERF_EN
    mem_perf_counter #(.W(PERF_W)) uMissCnt (
        .clk   (clk),
        .rstN  (rstN),
        .inc   (miss),
        .count (missCount)
    );

    mem_perf_counter #(.W(PERF_W)) uStallCnt (
        .clk   (clk),
        .rstN  (rstN),
        .inc   (stall),
        .count (stallCycles)
    );
`else
    assign missCount   = '0;
    assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized transaction-level bench for mem_stage_ctrl; expectations come from miss/handshake timing arithmetic.
module tb_mem_stage_ctrl;

    localparam int AW = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rstN;
    logic          memReadM, memWriteM, hitM, branchM, zeroM;
    logic [AW-1:0] addrM;
    logic          memReqValid, memReqReady, memReqWrite, memRespValid;
    logic [AW-1:0] memReqAddr;
    logic          stall, bubbleW, flushD, flushE, pcSrc;
    logic [PW-1:0] missCount, stallCycles;

    int nChk = 0;
    int nPass = 0;
    int expMiss = 0;
    int expStallCyc = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(AW), .PERF_W(PW)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .memReadM     (memReadM),
        .memWriteM    (memWriteM),
        .hitM         (hitM),
        .addrM        (addrM),
        .branchM      (branchM),
        .zeroM        (zeroM),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqAddr   (memReqAddr),
        .memReqWrite  (memReqWrite),
        .memRespValid (memRespValid),
        .stall        (stall),
        .bubbleW      (bubbleW),
        .flushD       (flushD),
        .flushE       (flushE),
        .pcSrc        (pcSrc),
        .missCount    (missCount),
        .stallCycles  (stallCycles)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic clearIn();
        memReadM     = 1'b0;
        memWriteM    = 1'b0;
        hitM         = 1'b0;
        addrM        = '0;
        branchM      = 1'b0;
        zeroM        = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
    endtask

    // Inputs were driven at a falling edge; check combinational and held outputs, then move to the next falling edge.
    task automatic sample(input string tag, input logic eStall, input logic eReqV, input logic ePc,
                          input logic [AW-1:0] eAddr, input logic eWr);
        #1;
        chk({tag, ".stall"}, 64'(stall), 64'(eStall));
        chk({tag, ".bubbleW"}, 64'(bubbleW), 64'(eStall));
        chk({tag, ".reqValid"}, 64'(memReqValid), 64'(eReqV));
        if (eReqV) begin
            chk({tag, ".reqAddr"}, 64'(memReqAddr), 64'(eAddr));
            chk({tag, ".reqWrite"}, 64'(memReqWrite), 64'(eWr));
        end
        chk({tag, ".pcSrc"}, 64'(pcSrc), 64'(ePc));
        chk({tag, ".flushD"}, 64'(flushD), 64'(ePc));
        chk({tag, ".flushE"}, 64'(flushE), 64'(ePc));
        @(negedge clk);
    endtask

    task automatic checkPerf(input string tag);
        int sat;
        sat = (1 << PW) - 1;
`ifdef MEM_CTRL_PERF_EN
        chk({tag, ".missCount"}, 64'(missCount), 64'((expMiss > sat) ? sat : expMiss));
        chk({tag, ".stallCycles"}, 64'(stallCycles), 64'((expStallCyc > sat) ? sat : expStallCyc));
`else
        chk({tag, ".missCount"}, 64'(missCount), 64'(0));
        chk({tag, ".stallCycles"}, 64'(stallCycles), 64'(0));
`endif
    endtask

    // One full miss: detect, request (held rdyDly extra cycles), wait (respDly extra cycles), replay, release.
    task automatic missTxn(input string tag, input bit isStore, input logic [AW-1:0] a,
                           input int rdyDly, input int respDly, input bit br);
        memReadM     = !isStore;
        memWriteM    = isStore;
        hitM         = 1'b0;
        addrM        = a;
        branchM      = br;
        zeroM        = br;
        memReqReady  = 1'($urandom_range(0, 1));
        memRespValid = 1'b0;
        sample({tag, ".detect"}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        expMiss++;
        expStallCyc += 4 + rdyDly + respDly;
        for (int i = 0; i <= rdyDly; i++) begin
            memReqReady  = (i == rdyDly);
            memRespValid = 1'($urandom_range(0, 1));
            addrM        = $urandom;
            sample({tag, ".req"}, 1'b1, 1'b1, 1'b0, a, isStore);
        end
        memReqReady = 1'($urandom_range(0, 1));
        for (int i = 0; i <= respDly; i++) begin
            memRespValid = (i == respDly);
            sample({tag, ".wait"}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        end
        addrM        = a;
        hitM         = 1'b1;
        memRespValid = 1'($urandom_range(0, 1));
        sample({tag, ".replay"}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        memRespValid = 1'($urandom_range(0, 1));
        sample({tag, ".release"}, 1'b0, 1'b0, br, '0, 1'b0);
        checkPerf(tag);
        if (br) begin
            clearIn();
            sample({tag, ".afterBr"}, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    // A cycle with no miss possible: any memory op hits, so only the branch rule matters.
    task automatic hitCyc();
        logic rd, wr, br, z;
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
        br = 1'($urandom_range(0, 1));
        z  = 1'($urandom_range(0, 1));
        memReadM     = rd;
        memWriteM    = wr;
        hitM         = (rd | wr) ? 1'b1 : 1'($urandom_range(0, 1));
        addrM        = $urandom;
        branchM      = br;
        zeroM        = z;
        memReqReady  = 1'($urandom_range(0, 1));
        memRespValid = 1'($urandom_range(0, 1));
        sample("hit", 1'b0, 1'b0, br & z, '0, 1'b0);
    endtask

    initial begin
        clearIn();
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        sample("reset", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("reset.reqAddr", 64'(memReqAddr), 64'(0));
        chk("reset.reqWrite", 64'(memReqWrite), 64'(0));
        checkPerf("reset");
        rstN = 1'b1;
        @(negedge clk);

        // Load hit
        memReadM = 1'b1;
        hitM     = 1'b1;
        addrM    = 32'h40;
        sample("loadHit", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        clearIn();

        missTxn("loadMiss", 1'b0, 32'h100, 0, 0, 1'b0);
        missTxn("storeMiss", 1'b1, 32'hABCD_0040, 3, 5, 1'b0);
        missTxn("brMiss", 1'b0, 32'h200, 1, 2, 1'b1);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 2) == 0)
                missTxn("rndMiss", 1'($urandom_range(0, 1)), $urandom,
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)));
            else
                hitCyc();
        end

        // Reset while waiting for the refill response
        clearIn();
        memWriteM = 1'b1;
        addrM     = 32'h300;
        sample("rstDetect", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        memReqReady = 1'b1;
        sample("rstReq", 1'b1, 1'b1, 1'b0, 32'h300, 1'b1);
        memReqReady = 1'b0;
        sample("rstWait", 1'b1, 1'b0, 1'b0, '0, 1'b0);
        #2;
        clearIn();
        rstN = 1'b0;
        #1;
        chk("rstAsync.reqValid", 64'(memReqValid), 64'(0));
        chk("rstAsync.stall", 64'(stall), 64'(0));
        chk("rstAsync.reqAddr", 64'(memReqAddr), 64'(0));
        expMiss = 0;
        expStallCyc = 0;
        checkPerf("rstAsync");
        @(negedge clk);
        rstN = 1'b1;
        memRespValid = 1'b1;
        sample("postRst0", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        sample("postRst1", 1'b0, 1'b0, 1'b0, '0, 1'b0);
        clearIn();
        missTxn("postRstMiss", 1'b0, 32'h400, 0, 1, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencing controller for the EX/MEM pipeline register and the data-cache miss path of the five-stage pipeline. Watches the memory-stage control bits and the cache hit flag registered in EX/MEM. On a load/store miss it freezes the front of the pipeline, runs a refill handshake with the next memory level, and replays the access. On a taken branch it redirects the PC and flushes the younger stages.

## Interface

Parameters:
- `ADDR_W`, default 32: width of the memory address.
- `PERF_W`, default 16: width of the performance counters (used only with `MEM_CTRL_PERF_EN`).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rstN`, in, 1: reset, asynchronous and active-low.
- `memReadM`, in, 1: MemRead from the EX/MEM register.
- `memWriteM`, in, 1: MemWrite from the EX/MEM register.
- `hitM`, in, 1: cache hit flag from the EX/MEM register.
- `addrM`, in, ADDR_W: ALU result (effective address) from the EX/MEM register.
- `branchM`, in, 1: Branch from the EX/MEM register.
- `zeroM`, in, 1: zero flag from the EX/MEM register.
- `memReqValid`, out, 1: refill request valid.
- `memReqReady`, in, 1: refill request accepted.
- `memReqAddr`, out, ADDR_W: refill address.
- `memReqWrite`, out, 1: the miss was a store (write-allocate).
- `memRespValid`, in, 1: refill data returned and written into the cache.
- `stall`, out, 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `bubbleW`, out, 1: load a no-op into MEM/WB.
- `flushD`, out, 1: clear IF/ID.
- `flushE`, out, 1: clear ID/EX.
- `pcSrc`, out, 1: select the branch target for the PC.
- `missCount`, out, PERF_W: number of misses.
- `stallCycles`, out, PERF_W: number of cycles with `stall` high.

## Operation

- Miss detection: `miss = (memReadM | memWriteM) & ~hitM & (state == IDLE)`.
- State machine states: IDLE, REQ, WAIT, REPLAY.
- IDLE -> REQ when `miss`. In the same edge, `addrM` is latched into `memReqAddr` and `memWriteM` into `memReqWrite`.
- REQ:
  - `memReqValid` = 1, with address and write bit held stable.
  - Go to WAIT on `memReqValid & memReqReady`.
  - `memRespValid` is ignored in REQ.
- WAIT: go to REPLAY when `memRespValid` = 1.
- REPLAY: one cycle, then go to IDLE. The cache has been refilled, so `hitM` is 1 when the access is re-evaluated in IDLE.
- A miss found again after REPLAY starts a new refill; this is legal and is not an error.
- `stall = miss | (state != IDLE)`. This is combinational, so the miss cycle is already stalled.
- `bubbleW = stall`.
- Branch:
  - `taken = branchM & zeroM & ~stall`.
  - `pcSrc = flushD = flushE = taken`.
- Simultaneous miss and taken branch: the miss wins. The branch stays held in EX/MEM and is taken in the first cycle after the stall releases.
- Reset:
  - `state` = IDLE, `memReqAddr` = 0, `memReqWrite` = 0, counters = 0.
  - `memReqValid`, `stall`, `bubbleW`, `flushD`, `flushE` and `pcSrc` are 0 while `rstN` = 0, provided the EX/MEM inputs are cleared.
  - Reset during REQ or WAIT abandons the refill immediately. A later `memRespValid` in IDLE is ignored.

## Timing

- Miss detected at cycle T. `stall` is high from T. `memReqValid` is high from T+1 (registered).
- Minimum stall, with `memReqReady` at T+1 and `memRespValid` at T+2: REPLAY at T+3, `stall` low at T+4. That is 4 stall cycles.
- Each cycle of ready delay or response delay adds one stall cycle.
- No timeout: WAIT is held indefinitely.
- Branch redirect costs zero extra cycles in the controller: `pcSrc`/flush follow in the same cycle that `branchM` and `zeroM` are visible.

## Configuration

- `MEM_CTRL_PERF_EN` defined:
  - `missCount` increments on each IDLE->REQ transition.
  - `stallCycles` increments on each cycle with `stall` = 1.
  - Both saturate at all-ones and clear on reset.
- `MEM_CTRL_PERF_EN` undefined: no counter flops; both outputs are tied to 0.

## Structure

- Shared package/include `mem_ctrl_pkg`:
  - State encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, REPLAY=2'd3.
  - Default `ADDR_W` and `PERF_W`.
- One sub-module, `mem_perf_counter`: a saturating counter with increment enable and async active-low clear. It is instantiated twice under `MEM_CTRL_PERF_EN`.
- The FSM, request latches and stall/flush logic live in `mem_stage_ctrl`.

## Test plan

1. Load hit: `memReadM`=1, `hitM`=1, `addrM`=0x40. Required: `stall`=0, `memReqValid` never asserted.
2. Load miss, 0-wait handshake:
   - Stimulus: `hitM`=0, `addrM`=0x100 at T; `memReqReady`=1 at T+1; `memRespValid`=1 at T+2; `hitM`=1 from T+3.
   - Required: `stall` high T..T+3, `memReqAddr`=0x100, `memReqWrite`=0, `stall` low at T+4, `missCount`=1.
3. Store miss with 3-cycle ready delay and 5-cycle response delay:
   - `memReqValid` stays high with `memReqWrite`=1 and a stable address until accepted.
   - `stallCycles` equals the cycles counted from T to REPLAY, inclusive.
4. Taken branch plus miss in the same cycle (`branchM`=`zeroM`=1, `memReadM`=1, `hitM`=0):
   - No `pcSrc` during the stall.
   - `pcSrc`/`flushD`/`flushE` pulse for exactly one cycle after `stall` falls.
5. Reset asserted while in WAIT:
   - `memReqValid`, `stall` and counters go to 0 immediately.
   - After release with `memRespValid`=1 and no miss: state stays IDLE.
6. Without `MEM_CTRL_PERF_EN`: rerun scenario 2. `missCount` and `stallCycles` stay 0.
